ex_stage: RTL and testbench

- Execute stage of the 64-bit RISC-V five-stage pipeline, directly downstream of the ID/EX pipeline register.
- Takes the operands and control bits decoded in ID and applies forwarding and the AluSrc immediate mux.
- Single-cycle ALU ops complete in one cycle; MUL uses an iterative multiplier FSM that stalls upstream.
- Results and control bits are registered into EX/MEM outputs for the MEM stage.

---
 rtl/ex_stage.sv | 140 ++++++++++++++
 tb/tb_ex_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: RV64 execute stage with forwarding, ALU, iterative MUL and EX/MEM register (EX_RADIX4_MUL_EN selects radix-4 MUL)
module ex_stage #(
  parameter int XLEN = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              AluSrc_in,
  input  logic              MemtoReg_in,
  input  logic              RegWrite_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [1:0]        Aluop_in,
  input  logic [2:0]        funct3_in,
  input  logic              funct7_5_in,
  input  logic              funct7_0_in,
  input  logic [XLEN-1:0]   rs1Data_in,
  input  logic [XLEN-1:0]   rs2Data_in,
  input  logic [XLEN-1:0]   immediate_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [1:0]        forwardA,
  input  logic [1:0]        forwardB,
  input  logic [XLEN-1:0]   ex_mem_fwd,
  input  logic [XLEN-1:0]   mem_wb_fwd,
  input  logic              flush,
  output logic              stall,
  output logic              ex_mem_valid,
  output logic [XLEN-1:0]   ex_mem_alu_result,
  output logic [XLEN-1:0]   ex_mem_store_data,
  output logic              ex_mem_zero,
  output logic [REG_AW-1:0] ex_mem_rd,
  output logic              ex_mem_MemtoReg,
  output logic              ex_mem_RegWrite,
  output logic              ex_mem_MemRead,
  output logic              ex_mem_MemWrite
);
  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;
`ifdef EX_RADIX4_MUL_EN
  localparam int STEPS = 32;
  localparam int SH = 2;
`else
  localparam int STEPS = 64;
  localparam int SH = 1;
`endif
  state_t state, state_nx;
  logic [6:0] cnt;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu, ma, mb, prod, res, step_add;
  logic [5:0] sh;
  logic is_mul, mul_start, bubble;
  assign fwd_a = forwardA == 2'b10 ? ex_mem_fwd : forwardA == 2'b01 ? mem_wb_fwd : rs1Data_in;
  assign fwd_b = forwardB == 2'b10 ? ex_mem_fwd : forwardB == 2'b01 ? mem_wb_fwd : rs2Data_in;
  assign op_b = AluSrc_in ? immediate_in : fwd_b;
  assign sh = op_b[5:0];
  assign is_mul = Aluop_in == 2'b10 && funct7_0_in && funct3_in == 3'b000;
  assign mul_start = state == IDLE && in_valid && is_mul && !flush;
  assign stall = rst && !flush && (mul_start || state == MUL_BUSY);
  assign bubble = stall || flush || !in_valid;
  assign res = state == MUL_DONE ? prod : alu;
`ifdef EX_RADIX4_MUL_EN
  assign step_add = (mb[0] ? ma : '0) + (mb[1] ? {ma[XLEN-2:0], 1'b0} : '0);
`else
  assign step_add = mb[0] ? ma : '0;
`endif
  always_comb begin
    alu = '0;
    if (Aluop_in == 2'b00) alu = fwd_a + op_b;
    else if (Aluop_in == 2'b01) alu = fwd_a - op_b;
    else if (!(Aluop_in == 2'b10 && funct7_0_in))
      case (funct3_in)
        3'b000: alu = (Aluop_in == 2'b10 && funct7_5_in) ? fwd_a - op_b : fwd_a + op_b;
        3'b001: alu = fwd_a << sh;
        3'b010: alu = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
        3'b011: alu = {{(XLEN-1){1'b0}}, fwd_a < op_b};
        3'b100: alu = fwd_a ^ op_b;
        3'b101: alu = funct7_5_in ? XLEN'($signed(fwd_a) >>> sh) : fwd_a >> sh;
        3'b110: alu = fwd_a | op_b;
        default: alu = fwd_a & op_b;
      endcase
  end
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (mul_start) state_nx = MUL_BUSY;
    else if (state == MUL_BUSY && cnt == 7'(STEPS - 1)) state_nx = MUL_DONE;
    else if (state == MUL_DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      prod <= '0;
    end else begin
      state <= state_nx;
      if (mul_start) begin
        ma <= fwd_a;
        mb <= fwd_b;
        prod <= '0;
        cnt <= '0;
      end else if (state == MUL_BUSY) begin
        prod <= prod + step_add;
        ma <= ma << SH;
        mb <= mb >> SH;
        cnt <= cnt + 7'd1;
      end
    end
  end
  // bubbles clear valid and control bits but leave data and rd untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_mem_valid <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_zero <= 1'b0;
      ex_mem_rd <= '0;
      ex_mem_MemtoReg <= 1'b0;
      ex_mem_RegWrite <= 1'b0;
      ex_mem_MemRead <= 1'b0;
      ex_mem_MemWrite <= 1'b0;
    end else if (bubble) begin
      ex_mem_valid <= 1'b0;
      ex_mem_MemtoReg <= 1'b0;
      ex_mem_RegWrite <= 1'b0;
      ex_mem_MemRead <= 1'b0;
      ex_mem_MemWrite <= 1'b0;
    end else begin
      ex_mem_valid <= 1'b1;
      ex_mem_alu_result <= res;
      ex_mem_store_data <= fwd_b;
      ex_mem_zero <= res == '0;
      ex_mem_rd <= rd_in;
      ex_mem_MemtoReg <= MemtoReg_in;
      ex_mem_RegWrite <= RegWrite_in;
      ex_mem_MemRead <= MemRead_in;
      ex_mem_MemWrite <= MemWrite_in;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
`ifdef EX_RADIX4_MUL_EN
  localparam int MUL_STALLS = 33;
`else
  localparam int MUL_STALLS = 65;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 0, AluSrc_in = 0, MemtoReg_in = 0, RegWrite_in = 0, MemRead_in = 0, MemWrite_in = 0;
  logic [1:0] Aluop_in = 0, forwardA = 0, forwardB = 0;
  logic [2:0] funct3_in = 0;
  logic funct7_5_in = 0, funct7_0_in = 0, flush = 0;
  logic [63:0] rs1Data_in = 0, rs2Data_in = 0, immediate_in = 0, ex_mem_fwd = 0, mem_wb_fwd = 0;
  logic [4:0] rd_in = 0;
  logic stall, ex_mem_valid, ex_mem_zero, ex_mem_MemtoReg, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite;
  logic [63:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0] ex_mem_rd;
  int checks = 0, errors = 0, sc, bub;
  ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .AluSrc_in(AluSrc_in), .MemtoReg_in(MemtoReg_in),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Aluop_in(Aluop_in),
    .funct3_in(funct3_in), .funct7_5_in(funct7_5_in), .funct7_0_in(funct7_0_in), .rs1Data_in(rs1Data_in),
    .rs2Data_in(rs2Data_in), .immediate_in(immediate_in), .rd_in(rd_in), .forwardA(forwardA),
    .forwardB(forwardB), .ex_mem_fwd(ex_mem_fwd), .mem_wb_fwd(mem_wb_fwd), .flush(flush), .stall(stall),
    .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
    .ex_mem_zero(ex_mem_zero), .ex_mem_rd(ex_mem_rd), .ex_mem_MemtoReg(ex_mem_MemtoReg),
    .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic op(input logic [1:0] aop, input logic [2:0] f3, input logic f75, input logic f70,
                    input logic [63:0] a, input logic [63:0] b);
    in_valid = 1; Aluop_in = aop; funct3_in = f3; funct7_5_in = f75; funct7_0_in = f70;
    rs1Data_in = a; rs2Data_in = b; AluSrc_in = 0; forwardA = 0; forwardB = 0;
  endtask
  initial begin
    #12;
    chk("rst_valid", {63'd0, ex_mem_valid}, 64'd0);
    chk("rst_result", ex_mem_alu_result, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk); rst = 1;
    op(2'b10, 3'b000, 0, 0, 64'd5, 64'd7); rd_in = 5'd9; RegWrite_in = 1;
    step;
    chk("add_result", ex_mem_alu_result, 64'd12);
    chk("add_rd", {59'd0, ex_mem_rd}, 64'd9);
    chk("add_valid", {63'd0, ex_mem_valid}, 64'd1);
    chk("add_zero", {63'd0, ex_mem_zero}, 64'd0);
    chk("add_regwrite", {63'd0, ex_mem_RegWrite}, 64'd1);
    op(2'b00, 3'b000, 0, 0, 64'd1, 64'd0); forwardA = 2'b10; ex_mem_fwd = 64'd100; AluSrc_in = 1; immediate_in = -64'sd4;
    step;
    chk("fwd_imm", ex_mem_alu_result, 64'd96);
    op(2'b01, 3'b000, 0, 0, 64'd3, 64'd3);
    step;
    chk("sub_zero_res", ex_mem_alu_result, 64'd0);
    chk("sub_zero_flag", {63'd0, ex_mem_zero}, 64'd1);
    op(2'b00, 3'b000, 0, 0, 64'd2, 64'd9); AluSrc_in = 1; immediate_in = 64'd1; forwardB = 2'b01; mem_wb_fwd = 64'h55; MemWrite_in = 1;
    step;
    chk("store_res", ex_mem_alu_result, 64'd3);
    chk("store_data", ex_mem_store_data, 64'h55);
    chk("store_memwrite", {63'd0, ex_mem_MemWrite}, 64'd1);
    MemWrite_in = 0;
    op(2'b10, 3'b000, 1, 0, 64'd10, 64'd3);
    step;
    chk("rtype_sub", ex_mem_alu_result, 64'd7);
    op(2'b11, 3'b000, 1, 0, 64'd10, 64'd0); AluSrc_in = 1; immediate_in = 64'd3;
    step;
    chk("itype_nosub", ex_mem_alu_result, 64'd13);
    op(2'b10, 3'b101, 1, 0, 64'h8000000000000000, 64'd63);
    step;
    chk("sra", ex_mem_alu_result, 64'hFFFFFFFFFFFFFFFF);
    op(2'b10, 3'b101, 0, 0, 64'h8000000000000000, 64'd63);
    step;
    chk("srl", ex_mem_alu_result, 64'd1);
    op(2'b10, 3'b001, 0, 0, 64'd3, 64'd4);
    step;
    chk("sll", ex_mem_alu_result, 64'd48);
    op(2'b10, 3'b010, 0, 0, 64'hFFFFFFFFFFFFFFFF, 64'd1);
    step;
    chk("slt", ex_mem_alu_result, 64'd1);
    op(2'b10, 3'b011, 0, 0, 64'hFFFFFFFFFFFFFFFF, 64'd1);
    step;
    chk("sltu", ex_mem_alu_result, 64'd0);
    op(2'b10, 3'b001, 0, 1, 64'd6, 64'd7);
    #1 chk("mext_nostall", {63'd0, stall}, 64'd0);
    step;
    chk("mext_zero", ex_mem_alu_result, 64'd0);
    chk("mext_valid", {63'd0, ex_mem_valid}, 64'd1);
    op(2'b10, 3'b000, 0, 1, 64'hFFFFFFFFFFFFFFFF, 64'd3); rd_in = 5'd4;
    #1 chk("mul_stall_now", {63'd0, stall}, 64'd1);
    sc = 0; bub = 0;
    while (stall && sc < 200) begin
      sc++;
      @(posedge clk);
      #1 if (ex_mem_valid === 1'b0 && ex_mem_RegWrite === 1'b0) bub++;
      @(negedge clk);
    end
    chk("mul_stall_cycles", 64'(sc), 64'(MUL_STALLS));
    chk("mul_bubbles", 64'(bub), 64'(MUL_STALLS));
    step;
    chk("mul_result", ex_mem_alu_result, 64'hFFFFFFFFFFFFFFFD);
    chk("mul_valid", {63'd0, ex_mem_valid}, 64'd1);
    chk("mul_rd", {59'd0, ex_mem_rd}, 64'd4);
    op(2'b10, 3'b000, 0, 1, 64'd5, 64'd6);
    repeat (11) step;
    flush = 1;
    #1 chk("flush_stall", {63'd0, stall}, 64'd0);
    step;
    chk("flush_bubble", {63'd0, ex_mem_valid}, 64'd0);
    chk("flush_regwrite", {63'd0, ex_mem_RegWrite}, 64'd0);
    flush = 0;
    op(2'b10, 3'b000, 0, 0, 64'd1, 64'd1);
    #1 chk("post_flush_stall", {63'd0, stall}, 64'd0);
    step;
    chk("post_flush_add", ex_mem_alu_result, 64'd2);
    chk("post_flush_valid", {63'd0, ex_mem_valid}, 64'd1);
    op(2'b10, 3'b000, 0, 1, 64'd7, 64'd8);
    repeat (5) step;
    #2 rst = 0;
    #1 chk("midrst_result", ex_mem_alu_result, 64'd0);
    chk("midrst_rd", {59'd0, ex_mem_rd}, 64'd0);
    chk("midrst_regwrite", {63'd0, ex_mem_RegWrite}, 64'd0);
    chk("midrst_stall", {63'd0, stall}, 64'd0);
    in_valid = 0;
    @(negedge clk); rst = 1;
    op(2'b10, 3'b000, 0, 0, 64'd2, 64'd3);
    #1 chk("after_rst_stall", {63'd0, stall}, 64'd0);
    step;
    chk("after_rst_add", ex_mem_alu_result, 64'd5);
    in_valid = 0;
    step;
    chk("invalid_bubble", {63'd0, ex_mem_valid}, 64'd0);
    chk("invalid_hold", ex_mem_alu_result, 64'd5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
